// File: rtl/reg_bank_arbiter_if.sv
// rtl/reg_bank_arbiter_if.sv - two write requesters, grants, busy and read port of the shared register bank
`timescale 1ns/1ps
interface reg_bank_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
);
  logic             req0;
  logic [AW-1:0]    addr0;
  logic [WIDTH-1:0] din0;
  logic             gnt0;
  logic             req1;
  logic [AW-1:0]    addr1;
  logic [WIDTH-1:0] din1;
  logic             gnt1;
  logic [AW-1:0]    raddr;
  logic [WIDTH-1:0] rdata;
  logic             busy;

  modport master (
    output req0, addr0, din0, req1, addr1, din1, raddr,
    input  gnt0, gnt1, rdata, busy
  );

  modport slave (
    input  req0, addr0, din0, req1, addr1, din1, raddr,
    output gnt0, gnt1, rdata, busy
  );
endinterface

// File: rtl/reg_bank_arbiter.sv
// rtl/reg_bank_arbiter.sv - round-robin arbitration of one register-bank write port between two requesters
`timescale 1ns/1ps
module reg_bank_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic              clk,
  input  logic              reset,
  reg_bank_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WRITE, ACK} state_t;

  state_t           state;
  logic             last;
  logic             gnt0_q;
  logic             gnt1_q;
  logic             busy_q;
  logic [AW-1:0]    cap_addr;
  logic [WIDTH-1:0] cap_data;
  logic [WIDTH-1:0] bank [DEPTH];
  logic             win1;

  // A tie goes to the requester that did not win the previous arbitration.
  assign win1 = bus.req1 & (~bus.req0 | ~last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      last     <= 1'b1;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      busy_q   <= 1'b0;
      cap_addr <= '0;
      cap_data <= '0;
      for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req0 | bus.req1) begin
            last     <= win1;
            cap_addr <= win1 ? bus.addr1 : bus.addr0;
            cap_data <= win1 ? bus.din1 : bus.din0;
            busy_q   <= 1'b1;
            state    <= WRITE;
          end
        end
        WRITE: begin
          bank[cap_addr] <= cap_data;
          gnt0_q         <= ~last;
          gnt1_q         <= last;
          state          <= ACK;
        end
        ACK: begin
          gnt0_q <= 1'b0;
          gnt1_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          gnt0_q <= 1'b0;
          gnt1_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt0  = gnt0_q;
  assign bus.gnt1  = gnt1_q;
  assign bus.busy  = busy_q;
  assign bus.rdata = bank[bus.raddr];
endmodule

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
Shares the single write port of a small register bank between two requesters using round-robin arbitration. The bank is built from WIDTH-bit edge-triggered D-flip-flop registers. A 3-state FSM sequences each write as capture, commit, then acknowledge. It sits between two producer blocks and the storage they share, and exposes one combinational read port.

Parameters:
WIDTH, 8, data width of each register
DEPTH, 4, number of registers in the bank
AW, 2, address width; DEPTH must equal 2**AW

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req0  in  1  write request from requester 0; held high until gnt0 is seen
addr0  in  AW  write address, requester 0
din0  in  WIDTH  write data, requester 0
gnt0  out  1  registered one-cycle acknowledge to requester 0
req1  in  1  write request from requester 1
addr1  in  AW  write address, requester 1
din1  in  WIDTH  write data, requester 1
gnt1  out  1  registered one-cycle acknowledge to requester 1
raddr  in  AW  read address
rdata  out  WIDTH  combinational read: bank[raddr]
busy  out  1  high when the FSM is not in IDLE

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - reset is asynchronous and active-high.
  - While reset is high: all bank registers are 0, gnt0=gnt1=0, busy=0, state=IDLE, last=1. Because last=1, requester 0 wins the first contested arbitration.
- FSM states: IDLE, WRITE, ACK.
- IDLE, at a rising edge with req0|req1 high:
  - Winner selection: a sole requester wins. If both request, the one not equal to last wins.
  - Capture the winner's addr and din into internal registers.
  - Set last=winner and go to WRITE.
  - With no request, stay in IDLE.
- WRITE, at the next edge:
  - bank[cap_addr] <= cap_data.
  - Set gnt of the winner to 1 and go to ACK. This transition is unconditional.
- ACK, at the next edge:
  - gnt0=gnt1=0 and go to IDLE. This transition is unconditional.
- Latency:
  - Request sampled at edge E0; data written at E1; gnt high for exactly one cycle, E1 to E2.
  - rdata reflects the new value from just after E1.
  - Minimum spacing between writes is 3 cycles, so a second request is sampled no earlier than E3.
- Requester protocol:
  - The requester holds req, addr and din stable until it samples gnt=1 at E2.
  - It drops req at E2 unless it has another write pending.
  - req still high in IDLE after ACK is treated as a new request.
- Only the captured values are used. Changes on addr/din/req after E0 do not affect the write in progress.
- req withdrawn during WRITE or ACK: the write still completes and gnt still pulses.
- gnt0 and gnt1 are never high in the same cycle.
- busy = (state != IDLE), registered with the state.
- Read during write: if raddr == cap_addr, rdata shows the old value until E1 and the new value after.
- The read port has no arbitration and is always valid.
- Fairness: with both requests held continuously, grants alternate 0,1,0,1,… Neither requester waits more than one other write.
- Reset mid-operation (in WRITE or ACK): asynchronous clear. Any pending write is lost, gnt drops immediately, and last returns to 1.

Test Plan:
- Reset check: hold reset=1 for 2 cycles, then release. Required: busy=0, gnt0=gnt1=0, rdata=0 for raddr=0..3.
- Single write: req0=1, addr0=2, din0=8'hA5, sampled at E0. Required: busy=1 after E0; rdata(raddr=2)=8'hA5 after E1; gnt0=1 only between E1 and E2; gnt1=0 throughout.
- Contention after reset: req0 (addr 1, 8'h11) and req1 (addr 1, 8'h22) raised together. Required: gnt0 first, then gnt1 three cycles later; final bank[1]=8'h22.
- Continuous contention: both requests held for 4 writes with distinct addresses. Required: grant order 0,1,0,1; each gnt exactly 1 cycle wide; never both high.
- Withdrawal: raise req1 (addr 3, 8'h3C), then drop it and change din1 during WRITE. Required: bank[3]=8'h3C and gnt1 still pulses once.
- Reset mid-op: assert reset during WRITE for a write of 8'hFF to addr 0. Required: bank[0]=0 and gnt=0 immediately. The next contested request is granted to requester 0.
